// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent up-counters sharing one prescaler tick.
// Each channel has CTRL {irqen, periodic, en}, STATUS (sticky match, W1C),
// COUNT and TARGET registers on a small 5-bit register map.
//
// Handshake: there is none. A write is accepted on every posedge clk where
// we=1 and addr decodes to an existing channel. Reads are purely combinational
// from addr with no valid/ready qualifier.
module multi_timer #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 32,
  parameter int PRESCALE       = 1,
  parameter int DEFAULT_TARGET = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          addr,
  input  logic [31:0]         dataIn,
  output logic [31:0]         dataOut,
  output logic [CHANNELS-1:0] flag,
  output logic                irq
);

  localparam logic [15:0]      PS_LAST = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TGT_RST = WIDTH'(DEFAULT_TARGET);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_TARGET = 2'd3;

  logic [15:0]         pre_q;
  logic                tick;
  logic [2:0]          ctrl_q   [CHANNELS];
  logic [CHANNELS-1:0] status_q;
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    target_q [CHANNELS];
  logic [CHANNELS-1:0] match;
  logic [CHANNELS-1:0] wr_ch;
  logic [1:0]          reg_sel;

  assign reg_sel = addr[1:0];
  assign tick    = (pre_q == PS_LAST);

  // Shared prescaler: free-running 0..PRESCALE-1, tick on the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

  // Per-channel match (on pre-update values) and write-select decode.
  always_comb begin
    match = '0;
    wr_ch = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      match[i] = tick && ctrl_q[i][0] && (count_q[i] == target_q[i]);
      wr_ch[i] = we && addr[4] && (addr[3:2] == 2'(i));
    end
  end

  // Channel registers: a software write beats the hardware update of the same
  // register, except STATUS where a hardware set beats a W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ctrl_q[i]   <= 3'b000;
        count_q[i]  <= '0;
        target_q[i] <= TGT_RST;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (match[i]) begin
          status_q[i] <= 1'b1;
        end else if (wr_ch[i] && reg_sel == REG_STATUS && dataIn[0]) begin
          status_q[i] <= 1'b0;
        end

        if (wr_ch[i] && reg_sel == REG_CTRL) begin
          ctrl_q[i] <= dataIn[2:0];
        end else if (match[i] && !ctrl_q[i][1]) begin
          ctrl_q[i][0] <= 1'b0;
        end

        if (wr_ch[i] && reg_sel == REG_COUNT) begin
          count_q[i] <= dataIn[WIDTH-1:0];
        end else if (match[i]) begin
          // Periodic restarts from 0; one-shot parks at TARGET.
          count_q[i] <= ctrl_q[i][1] ? '0 : count_q[i];
        end else if (tick && ctrl_q[i][0]) begin
          count_q[i] <= count_q[i] + WIDTH'(1);
        end

        if (wr_ch[i] && reg_sel == REG_TARGET) begin
          target_q[i] <= dataIn[WIDTH-1:0];
        end
      end
    end
  end

  // Read mux: unselected block or nonexistent channel reads 0.
  always_comb begin
    dataOut = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (addr[4] && addr[3:2] == 2'(i)) begin
        case (reg_sel)
          REG_CTRL:   dataOut = {29'd0, ctrl_q[i]};
          REG_STATUS: dataOut = {31'd0, status_q[i]};
          REG_COUNT:  dataOut = 32'(count_q[i]);
          default:    dataOut = 32'(target_q[i]);
        endcase
      end
    end
  end

  // Interrupt outputs straight from registered STATUS and CTRL.irqen.
  always_comb begin
    flag = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      flag[i] = status_q[i] & ctrl_q[i][2];
    end
    irq = |flag;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: instance A (2 ch, 32 bit, prescale 1) and
// instance B (2 ch, 8 bit, prescale 4) share clk/rst/addr/data.
module tb_multi_timer;

  localparam logic [4:0] C0 = 5'b10000;
  localparam logic [4:0] S0 = 5'b10001;
  localparam logic [4:0] N0 = 5'b10010;
  localparam logic [4:0] T0 = 5'b10011;
  localparam logic [4:0] C1 = 5'b10100;
  localparam logic [4:0] S1 = 5'b10101;
  localparam logic [4:0] N1 = 5'b10110;
  localparam logic [4:0] T1 = 5'b10111;

  logic        clk;
  logic        rst;
  logic        we_a;
  logic        we_b;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] dout_a;
  logic [31:0] dout_b;
  logic [1:0]  flag_a;
  logic [1:0]  flag_b;
  logic        irq_a;
  logic        irq_b;

  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  multi_timer #(
    .CHANNELS(2), .WIDTH(32), .PRESCALE(1), .DEFAULT_TARGET(500)
  ) u_dut_a (
    .clk(clk), .rst(rst), .we(we_a), .addr(addr), .dataIn(data_in),
    .dataOut(dout_a), .flag(flag_a), .irq(irq_a)
  );

  multi_timer #(
    .CHANNELS(2), .WIDTH(8), .PRESCALE(4), .DEFAULT_TARGET(500)
  ) u_dut_b (
    .clk(clk), .rst(rst), .we(we_b), .addr(addr), .dataIn(data_in),
    .dataOut(dout_b), .flag(flag_b), .irq(irq_b)
  );

  // Clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Advance n rising edges, settling 1ns after the last.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle register write to instance A (b=0) or B (b=1).
  task automatic wr(input bit b, input logic [4:0] a, input logic [31:0] d);
    addr    = a;
    data_in = d;
    we_a    = !b;
    we_b    = b;
    @(posedge clk);
    #1;
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  // Read: expected value queued as the address is driven, compared on settle.
  task automatic rd(input bit b, input logic [4:0] a, input logic [31:0] e, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    addr = a;
    exp_q.push_back(e);
    #1;
    got = b ? dout_b : dout_a;
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare a sampled output (flag/irq) against an expected value.
  task automatic chk(input logic [31:0] got, input logic [31:0] e, input string tag);
    logic [31:0] exp;
    exp_q.push_back(e);
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    we_a     = 1'b0;
    we_b     = 1'b0;
    addr     = 5'd0;
    data_in  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd(0, C0, 32'd0,   "rst_ctrl0");
    rd(0, S0, 32'd0,   "rst_status0");
    rd(0, N0, 32'd0,   "rst_count0");
    rd(0, T0, 32'd500, "rst_target0");
    rd(0, T1, 32'd500, "rst_target1");
    rd(1, T0, 32'd244, "rst_target0_w8");
    chk({30'd0, flag_a}, 32'd0, "rst_flag");
    chk({31'd0, irq_a},  32'd0, "rst_irq");

    // Periodic channel 0, TARGET=3
    wr(0, T0, 32'd3);
    wr(0, C0, 32'd7);
    rd(0, C0, 32'd7, "per_ctrl0");
    rd(0, N0, 32'd0, "per_cnt_a");
    step(1); rd(0, N0, 32'd1, "per_cnt_b");
    step(1); rd(0, N0, 32'd2, "per_cnt_c");
    step(1); rd(0, N0, 32'd3, "per_cnt_d");
    chk({30'd0, flag_a}, 32'd0, "per_flag_pre");
    step(1); rd(0, N0, 32'd0, "per_cnt_e");
    rd(0, S0, 32'd1, "per_status_set");
    chk({30'd0, flag_a}, 32'd1, "per_flag_set");
    chk({31'd0, irq_a},  32'd1, "per_irq_set");
    wr(0, S0, 32'd1);
    chk({30'd0, flag_a}, 32'd0, "per_flag_clr");
    chk({31'd0, irq_a},  32'd0, "per_irq_clr");
    rd(0, N0, 32'd1, "per_cnt_after_clr");
    step(2); chk({30'd0, flag_a}, 32'd0, "per_flag_pre2");
    step(1); chk({30'd0, flag_a}, 32'd1, "per_flag_again");
    rd(0, N0, 32'd0, "per_cnt_reload");

    // Collision: W1C in the match cycle loses to the set
    step(3); rd(0, N0, 32'd3, "col_cnt_pre");
    wr(0, S0, 32'd1);
    rd(0, S0, 32'd1, "col_w1c_set_wins");
    rd(0, N0, 32'd0, "col_w1c_cnt");
    wr(0, S0, 32'd1);
    rd(0, S0, 32'd0, "col_w1c_clear");
    step(2); rd(0, N0, 32'd3, "col_cnt_pre2");
    // Collision: COUNT write in the match cycle wins, STATUS still set
    wr(0, N0, 32'd10);
    rd(0, N0, 32'd10, "col_cnt_write");
    rd(0, S0, 32'd1,  "col_cnt_status");
    // CTRL write on a tick: count still advances on pre-write en
    wr(0, C0, 32'd0);
    rd(0, N0, 32'd11, "ctrl_wr_tick_cnt");
    step(2); rd(0, N0, 32'd11, "disabled_hold");

    // One-shot channel 1, TARGET=2
    wr(0, T1, 32'd2);
    wr(0, C1, 32'd5);
    step(2);
    rd(0, N1, 32'd2, "os_cnt_pre");
    rd(0, S1, 32'd0, "os_status_pre");
    step(1);
    rd(0, S1, 32'd1, "os_status_set");
    rd(0, C1, 32'd4, "os_en_cleared");
    rd(0, N1, 32'd2, "os_cnt_hold");
    chk({30'd0, flag_a}, 32'd2, "os_flag");
    chk({31'd0, irq_a},  32'd1, "os_irq");
    step(5); rd(0, N1, 32'd2, "os_cnt_hold_late");

    // Unmapped accesses
    rd(0, 5'b01010, 32'd0, "unsel_read");
    rd(0, 5'b11110, 32'd0, "ch3_read");
    rd(0, 5'b11011, 32'd0, "ch2_read");
    wr(0, 5'b11111, 32'd7);
    wr(0, 5'b00011, 32'd9);
    wr(0, 5'b01111, 32'd9);
    wr(0, 5'b11101, 32'd1);
    rd(0, T1, 32'd2, "unmapped_t1");
    rd(0, T0, 32'd3, "unmapped_t0");
    rd(0, S1, 32'd1, "unmapped_s1");

    // TARGET=0 periodic: match every tick, COUNT stays 0
    wr(0, S0, 32'd1);
    wr(0, T0, 32'd0);
    wr(0, N0, 32'd0);
    wr(0, C0, 32'd7);
    rd(0, S0, 32'd0, "t0_status_pre");
    step(1);
    rd(0, S0, 32'd1, "t0_status_set");
    rd(0, N0, 32'd0, "t0_cnt_a");
    chk({31'd0, irq_a}, 32'd1, "t0_irq");
    step(1); rd(0, N0, 32'd0, "t0_cnt_b");
    wr(0, S0, 32'd1);
    rd(0, S0, 32'd1, "t0_w1c_set_wins");

    // Reset mid-count on a match edge with irq=1
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(0, N0, 32'd0,   "mid_rst_cnt0");
    rd(0, T0, 32'd500, "mid_rst_t0");
    rd(0, C0, 32'd0,   "mid_rst_c0");
    rd(0, S0, 32'd0,   "mid_rst_s0");
    rd(0, C1, 32'd0,   "mid_rst_c1");
    rd(0, S1, 32'd0,   "mid_rst_s1");
    rd(0, N1, 32'd0,   "mid_rst_cnt1");
    rd(0, T1, 32'd500, "mid_rst_t1");
    rd(1, T0, 32'd244, "mid_rst_t0_w8");
    chk({30'd0, flag_a}, 32'd0, "mid_rst_flag");
    chk({31'd0, irq_a},  32'd0, "mid_rst_irq");

    // Instance B: prescale 4; ticks land on every 4th edge after reset
    wr(1, T0, 32'd1);
    step(2);
    wr(1, C0, 32'd3);
    step(3); rd(1, N0, 32'd0, "ps_cnt_hold");
    step(1); rd(1, N0, 32'd1, "ps_cnt_tick1");
    rd(1, S0, 32'd0, "ps_status_pre");
    step(3); rd(1, N0, 32'd1, "ps_cnt_hold2");
    rd(1, S0, 32'd0, "ps_status_pre2");
    step(1); rd(1, S0, 32'd1, "ps_status_clk8");
    rd(1, N0, 32'd0, "ps_cnt_reload");

    // Instance B channel 1: 8-bit wrap, high write bits dropped
    wr(1, T1, 32'd2);
    wr(1, N1, 32'hFFFF_FFFA);
    wr(1, C1, 32'd1);
    rd(1, N1, 32'd250, "w8_cnt_trunc");
    step(17); rd(1, N1, 32'd255, "w8_cnt_255");
    step(4);  rd(1, N1, 32'd0,   "w8_cnt_wrap");
    step(11); rd(1, N1, 32'd2,   "w8_cnt_at_tgt");
    rd(1, S1, 32'd0, "w8_status_pre");
    step(1);
    rd(1, S1, 32'd1, "w8_status_tick9");
    rd(1, N1, 32'd2, "w8_cnt_hold");
    rd(1, C1, 32'd0, "w8_en_cleared");

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, giving the number of independent timer channels (1..4).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the counter/target width (8..32).
REQ-003 The block SHALL have parameter PRESCALE, default 1, giving the clocks per count tick (1..65535).
REQ-004 The block SHALL have parameter DEFAULT_TARGET, default 500, giving the reset value of every TARGET register.
REQ-005 The block SHALL have port clk, input, 1 bit, the only clock; all state changes on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-007 The block SHALL have port we, input, 1 bit: register write strobe.
REQ-008 The block SHALL have port addr, input, 5 bits: register address (decode below).
REQ-009 The block SHALL have port dataIn, input, 32 bits: write data; bits above WIDTH are ignored for COUNT/TARGET.
REQ-010 The block SHALL have port dataOut, output, 32 bits: combinational read data for addr.
REQ-011 The block SHALL have port flag, output, CHANNELS bits: per-channel STATUS AND CTRL.irqen.
REQ-012 The block SHALL have port irq, output, 1 bit: OR of all flag bits.

Function
REQ-013 Decode SHALL be: selected when addr[4]=1; addr[3:2] is the channel; addr[1:0] is the register (00 CTRL, 01 STATUS, 10 COUNT, 11 TARGET).
REQ-014 With addr[4]=0, or a channel >= CHANNELS, writes SHALL be ignored and dataOut SHALL be 0.
REQ-015 CTRL SHALL be 3 bits: bit0 en, bit1 periodic, bit2 irqen; dataOut upper bits read 0.
REQ-016 STATUS SHALL be 1 bit, hardware-set on match; a write with dataIn[0]=1 clears it, and a write with dataIn[0]=0 has no effect.
REQ-017 A shared prescaler SHALL count 0..PRESCALE-1 continuously; tick SHALL be asserted for one clk when it equals PRESCALE-1; PRESCALE=1 SHALL tick every clk.
REQ-018 On tick with en=1, a channel SHALL evaluate match = (COUNT == TARGET) using the pre-update COUNT.
REQ-019 On tick with en=1 and no match, COUNT SHALL increment by 1 modulo 2^WIDTH; when COUNT > TARGET it SHALL wrap through 0 and continue to TARGET.
REQ-020 On match in periodic mode, STATUS SHALL be set and COUNT SHALL load 0 on the same edge (period = TARGET+1 ticks).
REQ-021 On match in one-shot mode, STATUS SHALL be set, en SHALL be cleared, and COUNT SHALL hold at TARGET.
REQ-022 When TARGET=0 in periodic mode, a match SHALL occur on every tick and COUNT SHALL remain 0.
REQ-023 With en=0, COUNT SHALL hold and no match SHALL be evaluated.
REQ-024 A register write in the same cycle as a tick update SHALL take precedence for the written register (COUNT/TARGET/CTRL); match SHALL still be evaluated on the pre-write values.
REQ-025 When a hardware set and a W1C of STATUS occur in the same cycle, the set SHALL win (STATUS=1).
REQ-026 Channels SHALL be fully independent apart from the shared tick.
REQ-027 flag and irq SHALL be combinational from registered STATUS/CTRL; the latency from the matching edge to flag SHALL be 0 cycles after that edge.

Reset
REQ-028 While rst=1 at posedge clk: the prescaler SHALL be 0; every COUNT 0; every TARGET DEFAULT_TARGET truncated to WIDTH; every CTRL 0; every STATUS 0.
REQ-029 rst SHALL override a simultaneous we and tick.
REQ-030 After reset, flag SHALL be all 0 and irq SHALL be 0.
REQ-031 Reset asserted mid-count SHALL abort all channels, with no STATUS set on that edge.

Verification
REQ-032 CHANNELS=2, PRESCALE=1: write TARGET0=3, CTRL0=3'b111 -> flag[0] and irq rise after the 4th tick edge and again every 4 clks after clearing STATUS0; COUNT0 reads 0,1,2,3,0.
REQ-033 One-shot: CTRL1=3'b101, TARGET1=2 -> STATUS1=1 after 3 ticks; CTRL1 reads 3'b100; COUNT1 holds 2 indefinitely.
REQ-034 PRESCALE=4, TARGET0=1, periodic -> STATUS0 set at clk 8 after enable; COUNT0 changes only every 4th clk.
REQ-035 Collisions: W1C on STATUS0 in the match cycle -> STATUS0=1; COUNT0 write of 10 in the match cycle -> COUNT0=10 and STATUS0=1.
REQ-036 WIDTH=8: COUNT0=250, TARGET0=2, enabled -> COUNT0 wraps 255->0; STATUS0 set after 9 ticks.
REQ-037 Assert rst mid-count with irq=1 -> next edge: all registers at reset values, irq=0; an access at addr=5'b01010 or to channel 3 (CHANNELS=2) -> dataOut=0, no state change.
